// File: rtl/cpu_control_if.sv
// Control <-> datapath/memory bundle for the LC-3b control FSM.
// aluop encoding: 0 add, 1 and, 2 not, 3 pass, 4 sll, 5 srl, 6 sra.
interface cpu_control_if;
    logic [3:0] opcode;
    logic       instruction4;
    logic       instruction5;
    logic       instruction11;
    logic       branch_enable;
    logic       mar_lsb;
    logic       mem_resp;

    logic [1:0] pcmux_sel;
    logic       storemux_sel;
    logic [2:0] alumux_sel;
    logic [1:0] marmux_sel;
    logic       mdrmux_sel;
    logic       offsetmux_sel;
    logic [2:0] regfilemux_sel;
    logic       destmux_sel;
    logic       load_pc;
    logic       load_cc;
    logic       load_ir;
    logic       load_mar;
    logic       load_mdr;
    logic       load_regfile;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       halted;
    logic       mem_error;

    modport master (
        input  opcode, instruction4, instruction5, instruction11, branch_enable, mar_lsb, mem_resp,
        output pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel, offsetmux_sel,
               regfilemux_sel, destmux_sel, load_pc, load_cc, load_ir, load_mar, load_mdr,
               load_regfile, aluop, mem_read, mem_write, mem_byte_enable, halted, mem_error
    );

    modport slave (
        output opcode, instruction4, instruction5, instruction11, branch_enable, mar_lsb, mem_resp,
        input  pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel, offsetmux_sel,
               regfilemux_sel, destmux_sel, load_pc, load_cc, load_ir, load_mar, load_mdr,
               load_regfile, aluop, mem_read, mem_write, mem_byte_enable, halted, mem_error
    );
endinterface

// File: rtl/cpu_control.sv
// Multicycle LC-3b control FSM: one state per cycle, outputs decoded from state and live inputs.
// Memory states wait on mem_resp; a watchdog parks the FSM in HALT if memory never answers.
module cpu_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    cpu_control_if.master bus
);
    localparam logic [3:0] OP_BR = 4'd0, OP_ADD = 4'd1, OP_LDB = 4'd2, OP_STB = 4'd3,
                           OP_JSR = 4'd4, OP_AND = 4'd5, OP_LDR = 4'd6, OP_STR = 4'd7,
                           OP_NOT = 4'd9, OP_LDI = 4'd10, OP_STI = 4'd11, OP_JMP = 4'd12,
                           OP_SHF = 4'd13, OP_LEA = 4'd14, OP_TRAP = 4'd15;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_AND = 3'd1, ALU_NOT = 3'd2, ALU_PASS = 3'd3,
                           ALU_SLL = 3'd4, ALU_SRL = 3'd5, ALU_SRA = 3'd6;
    localparam logic [8:0] TMO = MEM_TIMEOUT[8:0];

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_ALU, S_BR, S_CALC, S_RD1, S_IND,
        S_RD2, S_WB, S_STMDR, S_WR, S_LEA, S_JMP, S_JSR, S_TRAP, S_HALT
    } state_t;

    state_t     state_q, state_d, resp_next;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_error_q, mem_error_d;
    logic       mem_state, tmo_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH1;
            cnt_q       <= 8'd0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign tmo_hit = (MEM_TIMEOUT != 0) && (({1'b0, cnt_q} + 9'd1) >= TMO);
    assign bus.mem_error = mem_error_q;

    always_comb begin
        bus.pcmux_sel       = 2'd0;
        bus.storemux_sel    = 1'b0;
        bus.alumux_sel      = 3'd0;
        bus.marmux_sel      = 2'd0;
        bus.mdrmux_sel      = 1'b0;
        bus.offsetmux_sel   = 1'b0;
        bus.regfilemux_sel  = 3'd0;
        bus.destmux_sel     = 1'b0;
        bus.load_pc         = 1'b0;
        bus.load_cc         = 1'b0;
        bus.load_ir         = 1'b0;
        bus.load_mar        = 1'b0;
        bus.load_mdr        = 1'b0;
        bus.load_regfile    = 1'b0;
        bus.aluop           = ALU_ADD;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b11;
        bus.halted          = 1'b0;
        state_d             = state_q;
        resp_next           = state_q;
        cnt_d               = 8'd0;
        mem_error_d         = mem_error_q;
        mem_state           = 1'b0;

        // Outputs stay at defaults for the whole time reset is held, not just after the edge.
        if (reset_n) begin
            unique case (state_q)
                S_FETCH1: begin
                    bus.marmux_sel = 2'd1;
                    bus.load_mar   = 1'b1;
                    bus.load_pc    = 1'b1;
                    state_d        = S_FETCH2;
                end
                S_FETCH2: begin
                    bus.mem_read   = 1'b1;
                    bus.mdrmux_sel = 1'b1;
                    bus.load_mdr   = bus.mem_resp;
                    mem_state      = 1'b1;
                    resp_next      = S_FETCH3;
                end
                S_FETCH3: begin
                    bus.load_ir = 1'b1;
                    state_d     = S_DECODE;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_ADD, OP_AND, OP_NOT, OP_SHF:                 state_d = S_ALU;
                        OP_BR:                                          state_d = S_BR;
                        OP_LDR, OP_LDB, OP_LDI, OP_STR, OP_STB, OP_STI: state_d = S_CALC;
                        OP_LEA:                                         state_d = S_LEA;
                        OP_JMP:                                         state_d = S_JMP;
                        OP_JSR:                                         state_d = S_JSR;
                        OP_TRAP:                                        state_d = S_TRAP;
                        default:                                        state_d = S_FETCH1;
                    endcase
                end
                S_ALU: begin
                    bus.load_regfile = 1'b1;
                    bus.load_cc      = 1'b1;
                    bus.alumux_sel   = {2'b00, bus.instruction5};
                    case (bus.opcode)
                        OP_AND: bus.aluop = ALU_AND;
                        OP_NOT: bus.aluop = ALU_NOT;
                        OP_SHF: begin
                            bus.alumux_sel = 3'd3;
                            bus.aluop = !bus.instruction4 ? ALU_SLL :
                                        (!bus.instruction5 ? ALU_SRL : ALU_SRA);
                        end
                        default: bus.aluop = ALU_ADD;
                    endcase
                    state_d = S_FETCH1;
                end
                S_BR: begin
                    bus.pcmux_sel = 2'd1;
                    bus.load_pc   = bus.branch_enable;
                    state_d       = S_FETCH1;
                end
                S_CALC: begin
                    bus.load_mar   = 1'b1;
                    bus.alumux_sel = (bus.opcode == OP_LDB || bus.opcode == OP_STB) ? 3'd4 : 3'd2;
                    state_d = (bus.opcode == OP_STR || bus.opcode == OP_STB) ? S_STMDR : S_RD1;
                end
                S_RD1, S_RD2: begin
                    bus.mem_read   = 1'b1;
                    bus.mdrmux_sel = 1'b1;
                    bus.load_mdr   = bus.mem_resp;
                    mem_state      = 1'b1;
                    resp_next = (state_q == S_RD1 && (bus.opcode == OP_LDI || bus.opcode == OP_STI))
                                ? S_IND : S_WB;
                end
                S_IND: begin
                    bus.marmux_sel = 2'd2;
                    bus.load_mar   = 1'b1;
                    state_d        = (bus.opcode == OP_STI) ? S_STMDR : S_RD2;
                end
                S_WB: begin
                    bus.load_regfile   = 1'b1;
                    bus.load_cc        = 1'b1;
                    bus.regfilemux_sel = (bus.opcode == OP_LDB) ? (bus.mar_lsb ? 3'd5 : 3'd4) : 3'd1;
                    state_d            = S_FETCH1;
                end
                S_STMDR: begin
                    bus.storemux_sel = 1'b1;
                    bus.aluop        = ALU_PASS;
                    bus.load_mdr     = 1'b1;
                    state_d          = S_WR;
                end
                S_WR: begin
                    bus.mem_write = 1'b1;
                    if (bus.opcode == OP_STB)
                        bus.mem_byte_enable = bus.mar_lsb ? 2'b10 : 2'b01;
                    mem_state = 1'b1;
                    resp_next = S_FETCH1;
                end
                S_LEA: begin
                    bus.regfilemux_sel = 3'd2;
                    bus.load_regfile   = 1'b1;
                    bus.load_cc        = 1'b1;
                    state_d            = S_FETCH1;
                end
                S_JMP: begin
                    bus.pcmux_sel = 2'd2;
                    bus.load_pc   = 1'b1;
                    state_d       = S_FETCH1;
                end
                S_JSR: begin
                    bus.destmux_sel    = 1'b1;
                    bus.regfilemux_sel = 3'd3;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    bus.pcmux_sel      = bus.instruction11 ? 2'd1 : 2'd2;
                    bus.offsetmux_sel  = bus.instruction11;
                    state_d            = S_FETCH1;
                end
                S_TRAP: begin
                    bus.destmux_sel    = 1'b1;
                    bus.regfilemux_sel = 3'd3;
                    bus.load_regfile   = 1'b1;
                    bus.pcmux_sel      = 2'd3;
                    bus.load_pc        = 1'b1;
                    state_d            = S_FETCH1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: state_d = S_FETCH1;
            endcase

            // A response in the deadline cycle still completes the access.
            if (mem_state) begin
                if (bus.mem_resp) begin
                    state_d = resp_next;
                end else if (tmo_hit) begin
                    state_d     = S_HALT;
                    mem_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end
endmodule
